// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: command encodings, default bus widths
// and the port-ID width helper used to size tags.
package mem_arbiter_pkg;

    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int MEM_CMD_WIDTH     = 2;

    typedef enum logic [MEM_CMD_WIDTH-1:0] {
        MEM_CMD_READ  = 2'b00,
        MEM_CMD_WRITE = 2'b01
    } mem_cmd_e;

    // A single port still needs a one-bit tag so the FIFO has a storage width.
    function automatic int port_id_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order FIFO of port IDs for requests sent to memory but not yet answered.
// Latency: push visible at head the cycle after; head is combinational from storage.
// Backpressure: full/empty reported to the owner; push when full and pop when empty are ignored.
module mem_arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = store[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (do_push) begin
                store[wr_ptr] <= push_dat;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-port arbiter sharing one memory over valid/ready; MEM_ARB_STRICT_PRIO_EN selects lowest-index priority.
// Latency: accept to o_mem_valid 1 cycle; memory response to requester port 0 cycles.
// Backpressure: o_ready low while the output register is stalled or MAX_OUTSTANDING tags are in flight.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int ADDRESS_WIDTH   = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int CMD_WIDTH       = MEM_CMD_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           i_valid,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] i_address,
    input  logic [NUM_PORTS*CMD_WIDTH-1:0] i_cmd,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_data,
    output logic [NUM_PORTS-1:0]           o_ready,
    input  logic [NUM_PORTS-1:0]           i_res_ready,
    output logic [NUM_PORTS-1:0]           o_res_valid,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic                           o_mem_valid,
    output logic [ADDRESS_WIDTH-1:0]       o_mem_address,
    output logic [CMD_WIDTH-1:0]           o_mem_cmd,
    output logic [DATA_WIDTH-1:0]          o_mem_data,
    input  logic                           i_mem_ready,
    input  logic                           i_mem_res_valid,
    input  logic [DATA_WIDTH-1:0]          i_mem_data,
    output logic                           o_mem_res_ready,
    output logic                           o_err
);
    localparam int ID_W  = port_id_width(NUM_PORTS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic                     reg_free;
    logic                     grant_en;
    logic                     accept;
    logic [NUM_PORTS-1:0]     search_req;
    logic [ID_W-1:0]          win_id;
    logic [ADDRESS_WIDTH-1:0] win_address;
    logic [CMD_WIDTH-1:0]     win_cmd;
    logic [DATA_WIDTH-1:0]    win_data;
    logic [ID_W-1:0]          tag_head;
    logic                     tag_full;
    logic                     tag_empty;
    logic                     tag_pop;
    logic [CNT_W-1:0]         tag_count;

    // A pop in the same cycle does not relieve a full FIFO.
    assign reg_free = ~o_mem_valid | i_mem_ready;
    assign grant_en = reg_free & ~tag_full;
    assign accept   = grant_en & (|i_valid);

`ifdef MEM_ARB_STRICT_PRIO_EN
    assign search_req = i_valid;
`else
    logic [ID_W-1:0]      rr_ptr;
    logic [NUM_PORTS-1:0] upper_req;

    always_comb begin
        upper_req = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            upper_req[i] = i_valid[i] & (ID_W'(i) >= rr_ptr);
        end
    end

    // Ports at or above the pointer win first; otherwise the search wraps to port 0.
    assign search_req = (|upper_req) ? upper_req : i_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (win_id == ID_W'(NUM_PORTS - 1)) ? '0 : win_id + ID_W'(1);
        end
    end
`endif

    always_comb begin
        win_id      = '0;
        win_address = '0;
        win_cmd     = '0;
        win_data    = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (search_req[i]) begin
                win_id      = ID_W'(i);
                win_address = i_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                win_cmd     = i_cmd[i*CMD_WIDTH +: CMD_WIDTH];
                win_data    = i_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        o_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            o_ready[i] = grant_en & search_req[i] & (win_id == ID_W'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_mem_valid   <= 1'b0;
            o_mem_address <= '0;
            o_mem_cmd     <= '0;
            o_mem_data    <= '0;
        end else if (accept) begin
            o_mem_valid   <= 1'b1;
            o_mem_address <= win_address;
            o_mem_cmd     <= win_cmd;
            o_mem_data    <= win_data;
        end else if (i_mem_ready) begin
            o_mem_valid   <= 1'b0;
        end
    end

    mem_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_dat (win_id),
        .pop      (tag_pop),
        .head     (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    // With no tag in flight the response is swallowed so memory never hangs.
    always_comb begin
        o_res_valid     = '0;
        o_mem_res_ready = 1'b1;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (tag_head == ID_W'(k)) begin
                o_res_valid[k] = i_mem_res_valid & ~tag_empty;
                if (!tag_empty) begin
                    o_mem_res_ready = i_res_ready[k];
                end
            end
        end
    end

    assign o_data  = i_mem_data;
    assign tag_pop = i_mem_res_valid & o_mem_res_ready & ~tag_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_err <= 1'b0;
        end else if (i_mem_res_valid && (tag_count == '0)) begin
            o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (2 ports, 4 outstanding); expected response
// ports are queued at grant time and popped when the DUT delivers a response.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 2;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   i_valid;
    logic [NP*AW-1:0] i_address;
    logic [NP*CW-1:0] i_cmd;
    logic [NP*DW-1:0] i_data;
    logic [NP-1:0]   o_ready;
    logic [NP-1:0]   i_res_ready;
    logic [NP-1:0]   o_res_valid;
    logic [DW-1:0]   o_data;
    logic            o_mem_valid;
    logic [AW-1:0]   o_mem_address;
    logic [CW-1:0]   o_mem_cmd;
    logic [DW-1:0]   o_mem_data;
    logic            i_mem_ready;
    logic            i_mem_res_valid;
    logic [DW-1:0]   i_mem_data;
    logic            o_mem_res_ready;
    logic            o_err;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_ptr = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_PORTS       (NP),
        .ADDRESS_WIDTH   (AW),
        .DATA_WIDTH      (DW),
        .CMD_WIDTH       (CW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_valid         (i_valid),
        .i_address       (i_address),
        .i_cmd           (i_cmd),
        .i_data          (i_data),
        .o_ready         (o_ready),
        .i_res_ready     (i_res_ready),
        .o_res_valid     (o_res_valid),
        .o_data          (o_data),
        .o_mem_valid     (o_mem_valid),
        .o_mem_address   (o_mem_address),
        .o_mem_cmd       (o_mem_cmd),
        .o_mem_data      (o_mem_data),
        .i_mem_ready     (i_mem_ready),
        .i_mem_res_valid (i_mem_res_valid),
        .i_mem_data      (i_mem_data),
        .o_mem_res_ready (o_mem_res_ready),
        .o_err           (o_err)
    );

    function automatic logic [1:0] oh(input int p);
        return (p == 0) ? 2'b01 : 2'b10;
    endfunction

    // Reference arbitration: rotating pointer, or lowest valid index in strict mode.
    function automatic int exp_grant(input logic [1:0] v);
`ifdef MEM_ARB_STRICT_PRIO_EN
        return v[0] ? 0 : 1;
`else
        if (exp_ptr == 0) return v[0] ? 0 : 1;
        return v[1] ? 1 : 0;
`endif
    endfunction

    task automatic note_grant(input int g);
        exp_q.push_back(g);
`ifndef MEM_ARB_STRICT_PRIO_EN
        exp_ptr = (g + 1) % NP;
`endif
    endtask

    task automatic deliver(input logic [31:0] d);
        int p;
        @(negedge clk);
        i_mem_res_valid = 1'b1;
        i_mem_data      = d;
        i_res_ready     = 2'b11;
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL deliver_sb_empty got response for data %h want none pending", d);
        end else begin
            p = exp_q.pop_front();
            if (o_res_valid !== oh(p)) begin errors++; $display("FAIL resp_port got %b want %b", o_res_valid, oh(p)); end
        end
        checks++; if (o_data !== d) begin errors++; $display("FAIL resp_data got %h want %h", o_data, d); end
        checks++; if (o_mem_res_ready !== 1'b1) begin errors++; $display("FAIL resp_ready got %b want 1", o_mem_res_ready); end
    endtask

    task automatic test_reset();
        reset = 1'b0; i_valid = '0; i_address = '0; i_cmd = '0; i_data = '0;
        i_res_ready = 2'b11; i_mem_ready = 1'b1; i_mem_res_valid = 1'b0; i_mem_data = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (o_mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %b want 0", o_mem_valid); end
        checks++; if (o_mem_address !== '0) begin errors++; $display("FAIL rst_mem_address got %h want 0", o_mem_address); end
        checks++; if (o_mem_cmd !== '0) begin errors++; $display("FAIL rst_mem_cmd got %h want 0", o_mem_cmd); end
        checks++; if (o_mem_data !== '0) begin errors++; $display("FAIL rst_mem_data got %h want 0", o_mem_data); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", o_err); end
        checks++; if (o_res_valid !== 2'b00) begin errors++; $display("FAIL rst_res_valid got %b want 00", o_res_valid); end
        checks++; if (o_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b want 00", o_ready); end
        @(negedge clk);
        reset = 1'b1;
        exp_ptr = 0;
        exp_q.delete();
    endtask

    task automatic test_single_read();
        @(negedge clk);
        i_valid = 2'b01; i_address = {32'h0, 32'h10}; i_cmd = {MEM_CMD_READ, MEM_CMD_READ}; i_mem_ready = 1'b1;
        #1;
        checks++; if (o_ready !== oh(exp_grant(2'b01))) begin errors++; $display("FAIL rd_grant got %b want %b", o_ready, oh(exp_grant(2'b01))); end
        note_grant(exp_grant(2'b01));
        @(negedge clk);
        i_valid = 2'b00;
        #1;
        checks++; if (o_mem_valid !== 1'b1) begin errors++; $display("FAIL rd_mem_valid got %b want 1", o_mem_valid); end
        checks++; if (o_mem_address !== 32'h10) begin errors++; $display("FAIL rd_mem_address got %h want 10", o_mem_address); end
        checks++; if (o_mem_cmd !== MEM_CMD_READ) begin errors++; $display("FAIL rd_mem_cmd got %h want %h", o_mem_cmd, MEM_CMD_READ); end
        @(negedge clk);
        #1;
        checks++; if (o_mem_valid !== 1'b0) begin errors++; $display("FAIL rd_drained got %b want 0", o_mem_valid); end
        deliver(32'hDEADBEEF);
        @(negedge clk);
        i_mem_res_valid = 1'b0;
        #1;
        checks++; if (o_res_valid !== 2'b00) begin errors++; $display("FAIL rd_res_idle got %b want 00", o_res_valid); end
    endtask

    task automatic test_round_robin_full();
        int g;
        int p;
        for (int c = 0; c < MO; c++) begin
            @(negedge clk);
            i_valid = 2'b11; i_address = {32'h200, 32'h100}; i_data = {32'hB, 32'hA};
            i_cmd = {MEM_CMD_WRITE, MEM_CMD_READ};
            #1;
            g = exp_grant(2'b11);
            checks++; if (o_ready !== oh(g)) begin errors++; $display("FAIL rr_grant%0d got %b want %b", c, o_ready, oh(g)); end
            note_grant(g);
        end
        @(negedge clk);
        #1;
        checks++; if (o_ready !== 2'b00) begin errors++; $display("FAIL full_block got %b want 00", o_ready); end
        @(negedge clk);
        i_mem_res_valid = 1'b1; i_mem_data = 32'h1111; i_res_ready = 2'b11;
        #1;
        p = exp_q.pop_front();
        checks++; if (o_res_valid !== oh(p)) begin errors++; $display("FAIL full_pop_port got %b want %b", o_res_valid, oh(p)); end
        checks++; if (o_ready !== 2'b00) begin errors++; $display("FAIL full_pop_block got %b want 00", o_ready); end
        @(negedge clk);
        i_mem_res_valid = 1'b0;
        #1;
        g = exp_grant(2'b11);
        checks++; if (o_ready !== oh(g)) begin errors++; $display("FAIL regrant_after_pop got %b want %b", o_ready, oh(g)); end
        note_grant(g);
        @(negedge clk);
        i_valid = 2'b00;
        for (int k = 0; k < MO; k++) begin
            deliver(32'h2000 + k);
        end
        @(negedge clk);
        i_mem_res_valid = 1'b0;
    endtask

    task automatic test_stall();
        int g;
        @(negedge clk);
        i_mem_ready = 1'b0; i_valid = 2'b10;
        i_address = {32'h20, 32'h30}; i_data = {32'h55, 32'h66}; i_cmd = {MEM_CMD_WRITE, MEM_CMD_READ};
        #1;
        g = exp_grant(2'b10);
        checks++; if (o_ready !== oh(g)) begin errors++; $display("FAIL stall_grant got %b want %b", o_ready, oh(g)); end
        note_grant(g);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            i_valid = 2'b11;
            #1;
            checks++; if (o_mem_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got %b want 1", c, o_mem_valid); end
            checks++; if (o_mem_address !== 32'h20) begin errors++; $display("FAIL stall_addr%0d got %h want 20", c, o_mem_address); end
            checks++; if (o_mem_data !== 32'h55) begin errors++; $display("FAIL stall_data%0d got %h want 55", c, o_mem_data); end
            checks++; if (o_mem_cmd !== MEM_CMD_WRITE) begin errors++; $display("FAIL stall_cmd%0d got %h want %h", c, o_mem_cmd, MEM_CMD_WRITE); end
            checks++; if (o_ready !== 2'b00) begin errors++; $display("FAIL stall_no_grant%0d got %b want 00", c, o_ready); end
        end
        @(negedge clk);
        i_mem_ready = 1'b1;
        #1;
        g = exp_grant(2'b11);
        checks++; if (o_ready !== oh(g)) begin errors++; $display("FAIL drain_regrant got %b want %b", o_ready, oh(g)); end
        note_grant(g);
        @(negedge clk);
        i_valid = 2'b00;
        #1;
        checks++; if (o_mem_address !== ((g == 0) ? 32'h30 : 32'h20)) begin errors++; $display("FAIL b2b_addr got %h want %h", o_mem_address, (g == 0) ? 32'h30 : 32'h20); end
    endtask

    task automatic test_in_order();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            i_mem_res_valid = 1'b1; i_mem_data = 32'hA1; i_res_ready = 2'b01;
            #1;
            checks++; if (o_res_valid !== oh(exp_q[0])) begin errors++; $display("FAIL hold_valid%0d got %b want %b", c, o_res_valid, oh(exp_q[0])); end
            checks++; if (o_mem_res_ready !== 1'b0) begin errors++; $display("FAIL hold_ready%0d got %b want 0", c, o_mem_res_ready); end
        end
        deliver(32'hA1);
        deliver(32'hB0);
        @(negedge clk);
        i_mem_res_valid = 1'b0;
        #1;
        checks++; if (o_res_valid !== 2'b00) begin errors++; $display("FAIL order_idle got %b want 00", o_res_valid); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL order_no_err got %b want 0", o_err); end
    endtask

    task automatic test_reset_err();
        @(negedge clk);
        i_mem_ready = 1'b0; i_valid = 2'b11;
        @(negedge clk);
        i_valid = 2'b00;
        #1;
        checks++; if (o_mem_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b want 1", o_mem_valid); end
        #2 reset = 1'b0;
        #1;
        checks++; if (o_mem_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", o_mem_valid); end
        checks++; if (o_mem_address !== '0) begin errors++; $display("FAIL mid_rst_addr got %h want 0", o_mem_address); end
        checks++; if (o_mem_data !== '0) begin errors++; $display("FAIL mid_rst_data got %h want 0", o_mem_data); end
        checks++; if (o_res_valid !== 2'b00) begin errors++; $display("FAIL mid_rst_res_valid got %b want 00", o_res_valid); end
        exp_q.delete();
        exp_ptr = 0;
        @(negedge clk);
        reset = 1'b1; i_mem_ready = 1'b1;
        @(negedge clk);
        i_mem_res_valid = 1'b1; i_mem_data = 32'hBAD;
        #1;
        checks++; if (o_mem_res_ready !== 1'b1) begin errors++; $display("FAIL drop_ready got %b want 1", o_mem_res_ready); end
        checks++; if (o_res_valid !== 2'b00) begin errors++; $display("FAIL drop_no_valid got %b want 00", o_res_valid); end
        @(negedge clk);
        i_mem_res_valid = 1'b0;
        #1;
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", o_err); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", o_err); end
        reset = 1'b0;
        #1;
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", o_err); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog simulation did not finish within time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin_full();
        test_stall();
        test_in_order();
        test_reset_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Parametrised N-port arbiter letting several pipeline stages (fetch, memory stage, future DMA) share one memory module over the valid/ready request and response handshake.
- Registers one winning request per cycle toward memory.
- Records the winner's port ID in an in-order tag FIFO.
- Steers each memory response back to the port that issued it.
- Sits between the stage request ports and the memory instance at cpu top level.

Parameters:
NUM_PORTS, 2, number of requesting channels (1..8)
ADDRESS_WIDTH, 32, request address width
DATA_WIDTH, 32, read/write data width
CMD_WIDTH, 2, memory command width (MEM_CMD_* encoding)
MAX_OUTSTANDING, 4, accepted-but-unanswered request limit (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
i_valid  in  NUM_PORTS  per-port request valid
i_address  in  NUM_PORTS*ADDRESS_WIDTH  per-port address, port k in slice k
i_cmd  in  NUM_PORTS*CMD_WIDTH  per-port command
i_data  in  NUM_PORTS*DATA_WIDTH  per-port write data
o_ready  out  NUM_PORTS  one-hot grant; request k is accepted when i_valid[k] and o_ready[k] are both high
i_res_ready  in  NUM_PORTS  per-port response ready
o_res_valid  out  NUM_PORTS  per-port response valid
o_data  out  DATA_WIDTH  response data, shared by all ports
o_mem_valid  out  1  request to memory
o_mem_address  out  ADDRESS_WIDTH  request address
o_mem_cmd  out  CMD_WIDTH  request command
o_mem_data  out  DATA_WIDTH  request write data
i_mem_ready  in  1  memory accepts request
i_mem_res_valid  in  1  memory response valid
i_mem_data  in  DATA_WIDTH  memory response data
o_mem_res_ready  out  1  arbiter accepts response
o_err  out  1  sticky protocol error

Behaviour:
- Reset (reset low, async):
  - o_mem_valid=0, o_mem_address/o_mem_cmd/o_mem_data=0, o_err=0.
  - Tag FIFO empty; round-robin pointer=0.
  - Outstanding tags are discarded; the memory shares this reset.
- Output register:
  - Free when o_mem_valid=0, or when o_mem_valid & i_mem_ready (drains this cycle).
- Grant (combinational):
  - Granting is allowed only when the output register is free AND the tag FIFO is not full (count < MAX_OUTSTANDING).
  - Full blocks granting even if a pop occurs in the same cycle.
  - o_ready is one-hot to the winning requester, and all zero when no grant is allowed or no i_valid is set.
- Round-robin:
  - Search starts at the pointer and wraps modulo NUM_PORTS.
  - After a grant to port k, the pointer becomes (k+1) mod NUM_PORTS; otherwise it holds.
- Accept:
  - Next cycle: o_mem_valid=1 with the winner's address/cmd/data.
  - Winner ID is pushed into the tag FIFO. Latency is one cycle.
  - The output register holds stable until i_mem_ready.
  - Back-to-back acceptance is allowed when the register drains in the same cycle.
- Every accepted command (read or write) receives exactly one in-order response.
- Response path (combinational, zero latency):
  - h = FIFO head.
  - o_res_valid[h] = i_mem_res_valid & !empty; all other bits are 0.
  - o_data = i_mem_data.
  - o_mem_res_ready = i_res_ready[h] when not empty.
  - Pop when i_mem_res_valid & o_mem_res_ready.
- Simultaneous push and pop: count unchanged; head/tail pointers wrap modulo MAX_OUTSTANDING.
- Response with FIFO empty:
  - o_mem_res_ready=1 and the response is dropped.
  - No o_res_valid is raised.
  - o_err is set and stays set until reset.
- NUM_PORTS=1: degenerates to a registered pass-through with tag tracking.

Optional Feature:
- MEM_ARB_STRICT_PRIO_EN defined: fixed priority, lowest index wins. The pointer is not implemented and o_ready always goes to the lowest valid port.
- Undefined: round-robin as above.

Decomposition:
- Shared header: MEM_CMD_READ/MEM_CMD_WRITE encodings, ADDRESS_WIDTH/DATA_WIDTH defaults, and a clog2-based port-ID width macro.
- One sub-module, mem_arb_tag_fifo:
  - Parameters: depth MAX_OUTSTANDING, width clog2(NUM_PORTS).
  - Provides push, pop, head, full, empty, and count outputs.

Test Plan:
- Single port 0 read at addr 0x10, memory returns 0xDEADBEEF after 2 cycles -> o_mem_valid one cycle after accept with addr 0x10; o_res_valid[0]=1 with o_data=0xDEADBEEF; o_res_valid[1]=0.
- Ports 0 and 1 both valid continuously, i_mem_ready=1 -> grants alternate 0,1,0,1. Under MEM_ARB_STRICT_PRIO_EN, grants are always port 0.
- Memory withholds all responses, both ports requesting -> exactly 4 grants, then o_ready=0 until the first response pops; the next grant follows in the pop cycle+1.
- i_mem_ready=0 for 3 cycles holding a write (addr 0x20, data 0x55) -> o_mem_address/o_mem_data stable, no new o_ready, then accepted.
- Responses in order for tags 1,0 with i_res_ready[1]=0 for 2 cycles -> o_mem_res_ready=0 and response held; port 0 is not served out of order.
- Assert reset mid-traffic, then inject i_mem_res_valid with empty FIFO -> response dropped, o_err=1 and held; all outputs return to reset values during reset.
